// File: rtl/ula_sequencer_if.sv
// Unified memory port handshake between the main control FSM and the memory.
// The sequencer issues requests; the memory answers with mem_ready.
interface ula_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  adr_src,
    output mem_ready
  );
endinterface

// File: rtl/ula_sequencer.sv
// Multicycle RV32I main control FSM: one datapath step per cycle, memory wait
// states, illegal-opcode trap and a retired-instruction counter.
module ula_sequencer #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ula_sequencer_if.master      mem,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           ula_src_a,
  output logic [1:0]           ula_src_b,
  output logic [1:0]           ula_op,
  output logic [1:0]           result_src,
  output logic                 illegal,
  output logic [3:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEM_ADR = 4'd2;
  localparam logic [3:0] S_MEM_RD  = 4'd3;
  localparam logic [3:0] S_MEM_WB  = 4'd4;
  localparam logic [3:0] S_MEM_WR  = 4'd5;
  localparam logic [3:0] S_EXEC_R  = 4'd6;
  localparam logic [3:0] S_EXEC_I  = 4'd7;
  localparam logic [3:0] S_ALU_WB  = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_JAL     = 4'd10;
  localparam logic [3:0] S_LUI     = 4'd11;
  localparam logic [3:0] S_TRAP    = 4'd15;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic [3:0] next_state;
  logic       retire;
  logic       unused_funct3;

  assign unused_funct3 = ^funct3[2:1];

  always_comb begin
    next_state = S_TRAP;
    case (state)
      S_FETCH:   next_state = mem.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEM_ADR;
          OP_R:         next_state = S_EXEC_R;
          OP_I:         next_state = S_EXEC_I;
          OP_BRANCH:    next_state = S_BRANCH;
          OP_JAL:       next_state = S_JAL;
          OP_LUI:       next_state = S_LUI;
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEM_ADR: next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  next_state = mem.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:  next_state = S_FETCH;
      S_MEM_WR:  next_state = mem.mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:  next_state = S_ALU_WB;
      S_EXEC_I:  next_state = S_ALU_WB;
      S_ALU_WB:  next_state = S_FETCH;
      S_BRANCH:  next_state = S_FETCH;
      S_JAL:     next_state = S_ALU_WB;
      S_LUI:     next_state = S_ALU_WB;
      default:   next_state = S_TRAP;
    endcase
  end

  // An instruction retires on the edge that closes its last state into FETCH.
  assign retire = (state == S_MEM_WB) || (state == S_ALU_WB) ||
                  (state == S_BRANCH) || ((state == S_MEM_WR) && mem.mem_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= next_state;
      if (retire)
        instret <= instret + INSTRET_W'(1);
    end
  end

  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.adr_src = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    ula_src_a   = 2'b00;
    ula_src_b   = 2'b00;
    ula_op      = 2'b00;
    result_src  = 2'b00;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        ula_src_b   = 2'b10;
        result_src  = 2'b10;
        ir_write    = mem.mem_ready;
        pc_write    = mem.mem_ready;
      end
      S_DECODE: begin
        ula_src_a = 2'b01;
        ula_src_b = 2'b01;
      end
      S_MEM_ADR: begin
        ula_src_a = 2'b10;
        ula_src_b = 2'b01;
      end
      S_MEM_RD: begin
        mem.mem_req = 1'b1;
        mem.adr_src = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
      end
      S_MEM_WR: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        mem.adr_src = 1'b1;
      end
      S_EXEC_R: begin
        ula_src_a = 2'b10;
        ula_op    = 2'b10;
      end
      S_EXEC_I: begin
        ula_src_a = 2'b10;
        ula_src_b = 2'b01;
        ula_op    = 2'b10;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_BRANCH: begin
        ula_src_a = 2'b10;
        ula_op    = 2'b01;
        pc_write  = zero ^ funct3[0];
      end
      // Jump target comes from ALUOut while the ULA forms the link value.
      S_JAL: begin
        pc_write  = 1'b1;
        ula_src_a = 2'b01;
        ula_src_b = 2'b10;
      end
      S_LUI: begin
        ula_src_a = 2'b11;
        ula_src_b = 2'b01;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_ula_sequencer.sv
// Scoreboard bench for ula_sequencer: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_ula_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        ir_write, pc_write, reg_write, illegal;
  logic [1:0]  ula_src_a, ula_src_b, ula_op, result_src;
  logic [3:0]  state;
  logic [31:0] instret;

  ula_sequencer_if mem_bus ();

  ula_sequencer #(.INSTRET_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (mem_bus.master),
    .opcode     (opcode),
    .funct3     (funct3),
    .zero       (zero),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .ula_src_a  (ula_src_a),
    .ula_src_b  (ula_src_b),
    .ula_op     (ula_op),
    .result_src (result_src),
    .illegal    (illegal),
    .state      (state),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  // Word layout: state, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
  // ula_src_a, ula_src_b, ula_op, result_src, illegal.
  localparam logic [18:0] W_FETCH      = {4'd0,  6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
  localparam logic [18:0] W_FETCH_WAIT = {4'd0,  6'b100000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
  localparam logic [18:0] W_FETCH_RST  = {4'd0,  6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
  localparam logic [18:0] W_DECODE     = {4'd1,  6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] W_MEM_ADR    = {4'd2,  6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] W_MEM_RD     = {4'd3,  6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] W_MEM_WB     = {4'd4,  6'b000001, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0};
  localparam logic [18:0] W_MEM_WR     = {4'd5,  6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] W_MEM_WR_RST = {4'd5,  6'b001000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] W_EXEC_R     = {4'd6,  6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [18:0] W_EXEC_I     = {4'd7,  6'b000000, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0};
  localparam logic [18:0] W_ALU_WB     = {4'd8,  6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] W_BR_TAKEN   = {4'd9,  6'b000010, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [18:0] W_BR_NOT     = {4'd9,  6'b000000, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [18:0] W_JAL        = {4'd10, 6'b000010, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] W_LUI        = {4'd11, 6'b000000, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] W_TRAP       = {4'd15, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
  localparam logic [18:0] W_TRAP_RST   = {4'd15, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct {
    logic [18:0] word;
    logic [31:0] ic;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic z, input logic rdy, input logic rn,
                               input logic [18:0] word, input logic [31:0] ic,
                               input string name);
    exp_t e;
    #1;
    opcode            = op;
    funct3            = f3;
    zero              = z;
    mem_bus.mem_ready = rdy;
    rst_n             = rn;
    e.word = word;
    e.ic   = ic;
    e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [18:0] act;
    act = {state, mem_bus.mem_req, mem_bus.mem_we, mem_bus.adr_src, ir_write,
           pc_write, reg_write, ula_src_a, ula_src_b, ula_op, result_src, illegal};
    compared++;
    if (act !== e.word) begin
      mismatched++;
      $display("[TB] FAIL %s outputs: got %b required %b", e.name, act, e.word);
    end
    compared++;
    if (instret !== e.ic) begin
      mismatched++;
      $display("[TB] FAIL %s instret: got %0d required %0d", e.name, instret, e.ic);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0)
      checkOutput(sb_q.pop_front());
  end

  initial begin
    int budget;
    rst_n = 1'b0; opcode = OP_R; funct3 = 3'b000; zero = 1'b0;
    mem_bus.mem_ready = 1'b1;
    @(posedge clk);

    applyStimulus(OP_R, 3'b000, 1'b0, 1'b1, 1'b0, W_FETCH_RST, 0, "reset");

    applyStimulus(OP_R, 3'b000, 1'b0, 1'b1, 1'b1, W_FETCH,  0, "add fetch");
    applyStimulus(OP_R, 3'b000, 1'b0, 1'b1, 1'b1, W_DECODE, 0, "add decode");
    applyStimulus(OP_R, 3'b000, 1'b0, 1'b1, 1'b1, W_EXEC_R, 0, "add exec");
    applyStimulus(OP_R, 3'b000, 1'b0, 1'b1, 1'b1, W_ALU_WB, 0, "add wb");

    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, W_FETCH_WAIT, 1, "lw fetch wait");
    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b1, 1'b1, W_FETCH,      1, "lw fetch");
    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b1, 1'b1, W_DECODE,     1, "lw decode");
    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b1, 1'b1, W_MEM_ADR,    1, "lw adr");
    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, W_MEM_RD,     1, "lw rd w1");
    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, W_MEM_RD,     1, "lw rd w2");
    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b1, 1'b1, W_MEM_RD,     1, "lw rd done");
    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b1, 1'b1, W_MEM_WB,     1, "lw wb");

    applyStimulus(OP_BR, 3'b000, 1'b1, 1'b1, 1'b1, W_FETCH,    2, "beq fetch");
    applyStimulus(OP_BR, 3'b000, 1'b1, 1'b1, 1'b1, W_DECODE,   2, "beq decode");
    applyStimulus(OP_BR, 3'b000, 1'b1, 1'b1, 1'b1, W_BR_TAKEN, 2, "beq branch");

    applyStimulus(OP_BR, 3'b001, 1'b1, 1'b1, 1'b1, W_FETCH,  3, "bne fetch");
    applyStimulus(OP_BR, 3'b001, 1'b1, 1'b1, 1'b1, W_DECODE, 3, "bne decode");
    applyStimulus(OP_BR, 3'b001, 1'b1, 1'b1, 1'b1, W_BR_NOT, 3, "bne branch");

    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b1, 1'b1, W_FETCH,   4, "sw fetch");
    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b1, 1'b1, W_DECODE,  4, "sw decode");
    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b1, 1'b1, W_MEM_ADR, 4, "sw adr");
    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, W_MEM_WR,  4, "sw wr wait");
    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b1, 1'b1, W_MEM_WR,  4, "sw wr done");

    applyStimulus(OP_I, 3'b000, 1'b0, 1'b1, 1'b1, W_FETCH,  5, "addi fetch");
    applyStimulus(OP_I, 3'b000, 1'b0, 1'b1, 1'b1, W_DECODE, 5, "addi decode");
    applyStimulus(OP_I, 3'b000, 1'b0, 1'b1, 1'b1, W_EXEC_I, 5, "addi exec");
    applyStimulus(OP_I, 3'b000, 1'b0, 1'b1, 1'b1, W_ALU_WB, 5, "addi wb");

    applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b1, 1'b1, W_FETCH,  6, "jal fetch");
    applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b1, 1'b1, W_DECODE, 6, "jal decode");
    applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b1, 1'b1, W_JAL,    6, "jal jump");
    applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b1, 1'b1, W_ALU_WB, 6, "jal wb");

    applyStimulus(OP_LUI, 3'b000, 1'b0, 1'b1, 1'b1, W_FETCH,  7, "lui fetch");
    applyStimulus(OP_LUI, 3'b000, 1'b0, 1'b1, 1'b1, W_DECODE, 7, "lui decode");
    applyStimulus(OP_LUI, 3'b000, 1'b0, 1'b1, 1'b1, W_LUI,    7, "lui exec");
    applyStimulus(OP_LUI, 3'b000, 1'b0, 1'b1, 1'b1, W_ALU_WB, 7, "lui wb");

    applyStimulus(OP_BAD, 3'b000, 1'b0, 1'b1, 1'b1, W_FETCH,  8, "bad fetch");
    applyStimulus(OP_BAD, 3'b000, 1'b0, 1'b1, 1'b1, W_DECODE, 8, "bad decode");
    for (int i = 0; i < 10; i++)
      applyStimulus(OP_BAD, 3'b000, 1'b0, 1'b1, 1'b1, W_TRAP, 8, $sformatf("trap hold %0d", i));
    applyStimulus(OP_BAD, 3'b000, 1'b0, 1'b1, 1'b0, W_TRAP_RST, 8, "trap reset");

    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b1, 1'b1, W_FETCH,      0, "rsw fetch");
    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b1, 1'b1, W_DECODE,     0, "rsw decode");
    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b1, 1'b1, W_MEM_ADR,    0, "rsw adr");
    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b1, 1'b0, W_MEM_WR_RST, 0, "rsw wr reset");
    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b1, 1'b1, W_FETCH,      0, "rsw after reset");
    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b1, 1'b1, W_DECODE,     0, "rsw decode2");

    budget = 0;
    while (sb_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (sb_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
